pcs_receive: RTL and testbench

1000BASE-X PCS receive block: the counterpart of the PCS transmit block. It accepts aligned 10-bit code-groups from the synchronization stage and decodes them with 8b/10b and running-disparity checking. A Clause-36-style receive state machine then drives the GMII receive signals (RXD, RX_DV, RX_ER) and the `receiving` flag, which the transmit block uses for carrier and collision indication.

---
 rtl/pcs_receive_if.sv | 28 ++
 rtl/pcs_receive.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pcs_receive.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pcs_receive_if.sv
// GMII-side receive bundle for the 1000BASE-X PCS receive block:
// aligned code-groups and sync status in, decoded octets and status out.
interface pcs_receive_if;
  logic       sync_status;
  logic [9:0] rx_code_group;
  logic [7:0] RXD;
  logic       RX_DV;
  logic       RX_ER;
  logic       receiving;

  modport master (
    output sync_status,
    output rx_code_group,
    input  RXD,
    input  RX_DV,
    input  RX_ER,
    input  receiving
  );

  modport slave (
    input  sync_status,
    input  rx_code_group,
    output RXD,
    output RX_DV,
    output RX_ER,
    output receiving
  );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: 8b/10b decode with running-disparity check feeding a
// receive state machine that produces registered RXD/RX_DV/RX_ER/receiving.
module pcs_receive (
  input  logic         GTX_CLK,
  input  logic         mr_main_reset,
  pcs_receive_if.slave rx
);

  localparam logic [2:0] ST_LINK_FAILED   = 3'd0;
  localparam logic [2:0] ST_WAIT_FOR_K    = 3'd1;
  localparam logic [2:0] ST_RX_K          = 3'd2;
  localparam logic [2:0] ST_IDLE_D        = 3'd3;
  localparam logic [2:0] ST_FALSE_CARRIER = 3'd4;
  localparam logic [2:0] ST_RECEIVE       = 3'd5;
  localparam logic [2:0] ST_EPD           = 3'd6;

  localparam logic [7:0] OCT_PREAMBLE      = 8'h55;
  localparam logic [7:0] OCT_FALSE_CARRIER = 8'h0E;

  function automatic logic [2:0] f_ones6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  function automatic logic [2:0] f_ones4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  logic [2:0] r_state;
  logic       r_rd;         // running disparity, 1 = RD+
  logic [7:0] r_rxd;
  logic       r_rx_dv;
  logic       r_rx_er;
  logic       r_receiving;

  logic [5:0] w_6b;
  logic [3:0] w_4b;
  logic [2:0] w_ones6;
  logic [2:0] w_ones4;
  logic [4:0] w_x;
  logic       w_6_known;
  logic       w_6_k28;
  logic       w_6_legal;
  logic       w_rd_mid;
  logic       w_kx7;
  logic       w_alt_ok;
  logic [3:0] w_4k;
  logic [2:0] w_y;
  logic       w_4_legal;
  logic       w_k;
  logic       w_valid;
  logic       w_is_d;
  logic       w_is_k285;
  logic       w_is_s;
  logic       w_is_t;
  logic       w_is_r;
  logic       w_rd_base;
  logic       w_rd_next;

  logic [2:0] w_state_next;
  logic [7:0] w_rxd_next;
  logic       w_rx_dv_next;
  logic       w_rx_er_next;
  logic       w_receiving_next;

  assign w_6b    = rx.rx_code_group[9:4];
  assign w_4b    = rx.rx_code_group[3:0];
  assign w_ones6 = f_ones6(w_6b);
  assign w_ones4 = f_ones4(w_4b);

  // 5b/6b table: either RD form maps to the same EDCBA value
  always_comb begin
    w_x       = '0;
    w_6_known = 1'b1;
    w_6_k28   = 1'b0;
    case (w_6b)
      6'b100111, 6'b011000: w_x = 5'd0;
      6'b011101, 6'b100010: w_x = 5'd1;
      6'b101101, 6'b010010: w_x = 5'd2;
      6'b110001:            w_x = 5'd3;
      6'b110101, 6'b001010: w_x = 5'd4;
      6'b101001:            w_x = 5'd5;
      6'b011001:            w_x = 5'd6;
      6'b111000, 6'b000111: w_x = 5'd7;
      6'b111001, 6'b000110: w_x = 5'd8;
      6'b100101:            w_x = 5'd9;
      6'b010101:            w_x = 5'd10;
      6'b110100:            w_x = 5'd11;
      6'b001101:            w_x = 5'd12;
      6'b101100:            w_x = 5'd13;
      6'b011100:            w_x = 5'd14;
      6'b010111, 6'b101000: w_x = 5'd15;
      6'b011011, 6'b100100: w_x = 5'd16;
      6'b100011:            w_x = 5'd17;
      6'b010011:            w_x = 5'd18;
      6'b110010:            w_x = 5'd19;
      6'b001011:            w_x = 5'd20;
      6'b101010:            w_x = 5'd21;
      6'b011010:            w_x = 5'd22;
      6'b111010, 6'b000101: w_x = 5'd23;
      6'b110011, 6'b001100: w_x = 5'd24;
      6'b100110:            w_x = 5'd25;
      6'b010110:            w_x = 5'd26;
      6'b110110, 6'b001001: w_x = 5'd27;
      6'b001110:            w_x = 5'd28;
      6'b101110, 6'b010001: w_x = 5'd29;
      6'b011110, 6'b100001: w_x = 5'd30;
      6'b101011, 6'b010100: w_x = 5'd31;
      6'b001111, 6'b110000: begin
        w_x     = 5'd28;
        w_6_k28 = 1'b1;
      end
      default: w_6_known = 1'b0;
    endcase
  end

  // 6b legality against current RD; D7 is neutral but RD-dependent
  always_comb begin
    w_6_legal = 1'b0;
    if (w_6_known) begin
      if (w_ones6 == 3'd4)         w_6_legal = !r_rd;
      else if (w_ones6 == 3'd2)    w_6_legal = r_rd;
      else if (w_6b == 6'b111000)  w_6_legal = !r_rd;
      else if (w_6b == 6'b000111)  w_6_legal = r_rd;
      else                         w_6_legal = 1'b1;
    end
  end

  assign w_rd_mid = (w_ones6 > 3'd3) ? 1'b1 : (w_ones6 < 3'd3) ? 1'b0 : r_rd;
  assign w_kx7    = !w_6_k28 && ((w_x == 5'd23) || (w_x == 5'd27) ||
                                 (w_x == 5'd29) || (w_x == 5'd30));
  // D.x.A7 is mandatory where the primary .7 would create a run of five
  assign w_alt_ok = w_rd_mid ? ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))
                             : ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20));

  // 3b/4b table with legality against the RD left by the 6b sub-block
  always_comb begin
    w_y       = '0;
    w_4_legal = 1'b0;
    w_k       = 1'b0;
    w_4k      = w_rd_mid ? w_4b : ~w_4b;
    if (w_6_k28) begin
      w_k       = 1'b1;
      w_4_legal = 1'b1;
      case (w_4k)
        4'b0100: w_y = 3'd0;
        4'b1001: w_y = 3'd1;
        4'b0101: w_y = 3'd2;
        4'b0011: w_y = 3'd3;
        4'b0010: w_y = 3'd4;
        4'b1010: w_y = 3'd5;
        4'b0110: w_y = 3'd6;
        4'b1000: w_y = 3'd7;
        default: w_4_legal = 1'b0;
      endcase
    end else begin
      case (w_4b)
        4'b0100: begin w_y = 3'd0; w_4_legal = w_rd_mid;  end
        4'b1011: begin w_y = 3'd0; w_4_legal = !w_rd_mid; end
        4'b1001: begin w_y = 3'd1; w_4_legal = 1'b1;      end
        4'b0101: begin w_y = 3'd2; w_4_legal = 1'b1;      end
        4'b0011: begin w_y = 3'd3; w_4_legal = w_rd_mid;  end
        4'b1100: begin w_y = 3'd3; w_4_legal = !w_rd_mid; end
        4'b0010: begin w_y = 3'd4; w_4_legal = w_rd_mid;  end
        4'b1101: begin w_y = 3'd4; w_4_legal = !w_rd_mid; end
        4'b1010: begin w_y = 3'd5; w_4_legal = 1'b1;      end
        4'b0110: begin w_y = 3'd6; w_4_legal = 1'b1;      end
        4'b0001: begin w_y = 3'd7; w_4_legal = w_rd_mid && !w_alt_ok;  end
        4'b1110: begin w_y = 3'd7; w_4_legal = !w_rd_mid && !w_alt_ok; end
        4'b1000: begin
          w_y       = 3'd7;
          w_k       = w_kx7;
          w_4_legal = w_rd_mid && (w_kx7 || w_alt_ok);
        end
        4'b0111: begin
          w_y       = 3'd7;
          w_k       = w_kx7;
          w_4_legal = !w_rd_mid && (w_kx7 || w_alt_ok);
        end
        default: w_4_legal = 1'b0;
      endcase
    end
  end

  assign w_valid   = w_6_legal && w_4_legal;
  assign w_is_d    = w_valid && !w_k;
  assign w_is_k285 = w_valid && w_k && w_6_k28 && (w_y == 3'd5);
  assign w_is_s    = w_valid && w_k && !w_6_k28 && (w_x == 5'd27);
  assign w_is_t    = w_valid && w_k && !w_6_k28 && (w_x == 5'd29);
  assign w_is_r    = w_valid && w_k && !w_6_k28 && (w_x == 5'd23);

  // Invalid groups resync RD from the 4b sub-block only
  assign w_rd_base = w_valid ? w_rd_mid : r_rd;
  assign w_rd_next = (w_ones4 > 3'd2) ? 1'b1 : (w_ones4 < 3'd2) ? 1'b0 : w_rd_base;

  // Next state and next registered outputs for the current code-group
  always_comb begin
    w_state_next     = r_state;
    w_rxd_next       = '0;
    w_rx_dv_next     = 1'b0;
    w_rx_er_next     = 1'b0;
    w_receiving_next = 1'b0;
    if (!rx.sync_status) begin
      w_state_next = ST_LINK_FAILED;
      if (r_state == ST_RECEIVE) begin
        w_rx_dv_next     = 1'b1;
        w_rx_er_next     = 1'b1;
        w_receiving_next = 1'b1;
      end
    end else begin
      case (r_state)
        ST_LINK_FAILED: w_state_next = ST_WAIT_FOR_K;
        ST_WAIT_FOR_K: begin
          if (w_is_k285) w_state_next = ST_RX_K;
        end
        ST_RX_K: w_state_next = w_is_d ? ST_IDLE_D : ST_WAIT_FOR_K;
        ST_IDLE_D: begin
          if (w_is_k285) begin
            w_state_next = ST_RX_K;
          end else if (w_is_s) begin
            w_state_next     = ST_RECEIVE;
            w_rxd_next       = OCT_PREAMBLE;
            w_rx_dv_next     = 1'b1;
            w_receiving_next = 1'b1;
          end else begin
            w_state_next     = ST_FALSE_CARRIER;
            w_rxd_next       = OCT_FALSE_CARRIER;
            w_rx_er_next     = 1'b1;
            w_receiving_next = 1'b1;
          end
        end
        ST_FALSE_CARRIER: begin
          if (w_is_k285) begin
            w_state_next = ST_RX_K;
          end else begin
            w_rxd_next       = OCT_FALSE_CARRIER;
            w_rx_er_next     = 1'b1;
            w_receiving_next = 1'b1;
          end
        end
        ST_RECEIVE: begin
          if (w_is_d) begin
            w_rxd_next       = {w_y, w_x};
            w_rx_dv_next     = 1'b1;
            w_receiving_next = 1'b1;
          end else if (w_is_t) begin
            w_state_next = ST_EPD;
          end else begin
            // early end (comma) and /V/, /S/, /R/ all flag an errored octet
            if (w_is_k285) w_state_next = ST_RX_K;
            w_rx_dv_next     = 1'b1;
            w_rx_er_next     = 1'b1;
            w_receiving_next = 1'b1;
          end
        end
        ST_EPD: begin
          if (w_is_k285)   w_state_next = ST_RX_K;
          else if (!w_is_r) w_state_next = ST_WAIT_FOR_K;
        end
        default: w_state_next = ST_LINK_FAILED;
      endcase
    end
  end

  // State, running disparity and output registers
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      r_state     <= ST_LINK_FAILED;
      r_rd        <= 1'b0;
      r_rxd       <= '0;
      r_rx_dv     <= 1'b0;
      r_rx_er     <= 1'b0;
      r_receiving <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd        <= w_rd_next;
      r_rxd       <= w_rxd_next;
      r_rx_dv     <= w_rx_dv_next;
      r_rx_er     <= w_rx_er_next;
      r_receiving <= w_receiving_next;
    end
  end

  assign rx.RXD       = r_rxd;
  assign rx.RX_DV     = r_rx_dv;
  assign rx.RX_ER     = r_rx_er;
  assign rx.receiving = r_receiving;

endmodule

// File: tb/tb_pcs_receive.sv
// Directed bench for pcs_receive; each expected output is hand-derived from the
// 8b/10b tables and the receive state machine.
module tb_pcs_receive;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  pcs_receive_if u_if ();

  pcs_receive u_dut (
    .GTX_CLK       (clk),
    .mr_main_reset (rst),
    .rx            (u_if.slave)
  );

  always #5 clk = ~clk;

  // {RXD, RX_DV, RX_ER, receiving}
  wire [10:0] w_obs = {u_if.RXD, u_if.RX_DV, u_if.RX_ER, u_if.receiving};

  task automatic tick(input logic [9:0] cg);
    u_if.rx_code_group = cg;
    @(posedge clk);
    #1;
  endtask

  // reset, then LINK_FAILED -> WAIT_FOR_K -> RX_K -> IDLE_D with RD- at the end
  task automatic to_idle();
    rst = 1'b1;
    u_if.sync_status = 1'b1;
    #3;
    rst = 1'b0;
    tick(10'h296);
    tick(10'h0FA);
    tick(10'h245);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.sync_status = 1'b0;
    u_if.rx_code_group = 10'h0FA;
    #2;
    n_checks++;
    if (w_obs !== 11'h000) $display("FAIL reset_async: got rxd=%h dv=%b er=%b rcv=%b required all zero", w_obs[10:3], w_obs[2], w_obs[1], w_obs[0]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (w_obs !== 11'h000) $display("FAIL reset_held: got rxd=%h dv=%b er=%b rcv=%b required all zero", w_obs[10:3], w_obs[2], w_obs[1], w_obs[0]);
    else n_pass++;
    rst = 1'b0;
    tick(10'h0FA);
    n_checks++;
    if (w_obs !== 11'h000) $display("FAIL nosync_idle: got rxd=%h dv=%b er=%b rcv=%b required all zero", w_obs[10:3], w_obs[2], w_obs[1], w_obs[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    logic [9:0]  cg [7];
    logic [10:0] ex [7];
    cg = '{10'h368, 10'h296, 10'h296, 10'h0FA, 10'h245, 10'h368, 10'h2E8};
    ex = '{{8'h55, 3'b101}, {8'hC5, 3'b101}, 11'h000, 11'h000, 11'h000,
           {8'h55, 3'b101}, 11'h000};
    to_idle();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== 11'h000) $display("FAIL mid_reset_async: got rxd=%h dv=%b er=%b rcv=%b required all zero", w_obs[10:3], w_obs[2], w_obs[1], w_obs[0]);
        else n_pass++;
        #1;
        rst = 1'b0;
      end
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL mid_reset[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_packet();
    logic [9:0]  cg [9];
    logic [10:0] ex [9];
    cg = '{10'h368, 10'h296, 10'h274, 10'h2E8, 10'h3A8, 10'h0FA, 10'h245, 10'h368, 10'h2E8};
    ex = '{{8'h55, 3'b101}, {8'hC5, 3'b101}, {8'h00, 3'b101}, 11'h000, 11'h000,
           11'h000, 11'h000, {8'h55, 3'b101}, 11'h000};
    to_idle();
    for (int i = 0; i < 9; i++) begin
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL packet[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_false_carrier();
    logic [9:0]  cg [7];
    logic [10:0] ex [7];
    cg = '{10'h274, 10'h296, 10'h368, 10'h0FA, 10'h245, 10'h368, 10'h2E8};
    ex = '{{8'h0E, 3'b011}, {8'h0E, 3'b011}, {8'h0E, 3'b011}, 11'h000, 11'h000,
           {8'h55, 3'b101}, 11'h000};
    to_idle();
    for (int i = 0; i < 7; i++) begin
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL false_carrier[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_disparity_error();
    logic [9:0]  cg [5];
    logic [10:0] ex [5];
    // 0x305 is K28.5 RD+ seen at RD-; 0x1E8 is a valid but unrecognised K30.7
    cg = '{10'h368, 10'h305, 10'h296, 10'h1E8, 10'h2E8};
    ex = '{{8'h55, 3'b101}, {8'h00, 3'b111}, {8'hC5, 3'b101}, {8'h00, 3'b111}, 11'h000};
    to_idle();
    for (int i = 0; i < 5; i++) begin
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL disparity[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_early_end();
    logic [9:0]  cg [6];
    logic [10:0] ex [6];
    cg = '{10'h368, 10'h296, 10'h0FA, 10'h245, 10'h368, 10'h2E8};
    ex = '{{8'h55, 3'b101}, {8'hC5, 3'b101}, {8'h00, 3'b111}, 11'h000,
           {8'h55, 3'b101}, 11'h000};
    to_idle();
    for (int i = 0; i < 6; i++) begin
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL early_end[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_link_loss();
    logic [9:0]  cg [9];
    logic        sy [9];
    logic [10:0] ex [9];
    cg = '{10'h368, 10'h296, 10'h296, 10'h296, 10'h368, 10'h0FA, 10'h245, 10'h368, 10'h2E8};
    sy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex = '{{8'h55, 3'b101}, {8'h00, 3'b111}, 11'h000, 11'h000, 11'h000,
           11'h000, 11'h000, {8'h55, 3'b101}, 11'h000};
    to_idle();
    for (int i = 0; i < 9; i++) begin
      u_if.sync_status = sy[i];
      tick(cg[i]);
      n_checks++;
      if (w_obs !== ex[i]) $display("FAIL link_loss[%0d]: got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b", i, w_obs[10:3], w_obs[2], w_obs[1], w_obs[0], ex[i][10:3], ex[i][2], ex[i][1], ex[i][0]);
      else n_pass++;
    end
  endtask

  initial begin
    u_if.sync_status   = 1'b0;
    u_if.rx_code_group = 10'h000;
    test_reset();
    test_reset_mid_stream();
    test_packet();
    test_false_carrier();
    test_disparity_error();
    test_early_end();
    test_link_loss();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
